// File: rtl/zeroriscy_hpm_unit.sv
// HPM event counters with evsel/inhibit/sticky-overflow CSRs; CSR reads combinational, event->read 2 cycles, no backpressure.
// Optional ZERORISCY_HPM_OVF_IRQ_EN adds irq-enable CSR 0x7C1 and a registered ovf_irq_o.
module zeroriscy_hpm_unit #(
    parameter int unsigned N_COUNTERS = 4,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned N_EVENTS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [1:0]          csr_op_i,
    input  logic [31:0]         csr_wdata_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] event_i,
    output logic                ovf_irq_o
);

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: csr_apply = wdata;
            CSR_OP_SET:   csr_apply = old | wdata;
            CSR_OP_CLEAR: csr_apply = old & ~wdata;
            default:      csr_apply = old;
        endcase
    endfunction

    logic [CNT_WIDTH-1:0]  cnt_q   [N_COUNTERS];
    logic [CNT_WIDTH-1:0]  cnt_d   [N_COUNTERS];
    logic [63:0]           cnt_ext [N_COUNTERS];
    logic [4:0]            evsel_q [N_COUNTERS];
    logic [4:0]            evsel_d [N_COUNTERS];
    logic [N_COUNTERS-1:0] inhibit_q, inhibit_d;
    logic [N_COUNTERS-1:0] ovf_q, ovf_d, ovf_set;
    logic [N_COUNTERS-1:0] inc_q, inc_d;
    logic [N_COUNTERS-1:0] irq_en_q;

    logic [N_COUNTERS-1:0] sel_lo, sel_hi, sel_ev;
    logic                  sel_inh, sel_ovf, sel_irqen;
    logic                  wr_en;
    logic [31:0]           ev_vec;

    // Bit k of ev_vec is event k-1, so evsel=0 and evsel>N_EVENTS land on zero bits.
    assign ev_vec = 32'(event_i) << 1;

    always_comb begin
        sel_lo    = '0;
        sel_hi    = '0;
        sel_ev    = '0;
        sel_inh   = csr_access_i && (csr_addr_i == 12'h320);
        sel_ovf   = csr_access_i && (csr_addr_i == 12'h7C0);
        sel_irqen = 1'b0;
`ifdef ZERORISCY_HPM_OVF_IRQ_EN
        sel_irqen = csr_access_i && (csr_addr_i == 12'h7C1);
`endif
        for (int i = 0; i < int'(N_COUNTERS); i++) begin
            cnt_ext[i] = 64'(cnt_q[i]);
            sel_lo[i]  = csr_access_i && (csr_addr_i == 12'(12'hB03 + i));
            sel_hi[i]  = csr_access_i && (csr_addr_i == 12'(12'hB83 + i));
            sel_ev[i]  = csr_access_i && (csr_addr_i == 12'(12'h323 + i));
        end
    end

    assign csr_hit_o = (|sel_lo) | (|sel_hi) | (|sel_ev) | sel_inh | sel_ovf | sel_irqen;
    assign wr_en     = csr_hit_o && (csr_op_i != CSR_OP_NONE);

    always_comb begin
        csr_rdata_o = '0;
        for (int i = 0; i < int'(N_COUNTERS); i++) begin
            if (sel_lo[i]) csr_rdata_o = cnt_ext[i][31:0];
            if (sel_hi[i]) csr_rdata_o = cnt_ext[i][63:32];
            if (sel_ev[i]) csr_rdata_o = 32'(evsel_q[i]);
        end
        if (sel_inh)   csr_rdata_o = 32'(inhibit_q);
        if (sel_ovf)   csr_rdata_o = 32'(ovf_q);
        if (sel_irqen) csr_rdata_o = 32'(irq_en_q);
    end

    always_comb begin
        cnt_d     = cnt_q;
        evsel_d   = evsel_q;
        inhibit_d = inhibit_q;
        ovf_d     = ovf_q;
        ovf_set   = '0;
        inc_d     = '0;
        for (int i = 0; i < int'(N_COUNTERS); i++) begin
            inc_d[i] = ev_vec[evsel_q[i]] & ~inhibit_q[i];
            // A CSR write to either half swallows the pending increment.
            if (wr_en && sel_lo[i]) begin
                cnt_d[i][31:0] = csr_apply(csr_op_i, cnt_ext[i][31:0], csr_wdata_i);
            end else if (wr_en && sel_hi[i]) begin
                cnt_d[i][CNT_WIDTH-1:32] =
                    (CNT_WIDTH-32)'(csr_apply(csr_op_i, cnt_ext[i][63:32], csr_wdata_i));
            end else if (inc_q[i]) begin
                cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
                ovf_set[i] = &cnt_q[i];
            end
            if (wr_en && sel_ev[i]) begin
                evsel_d[i] = 5'(csr_apply(csr_op_i, 32'(evsel_q[i]), csr_wdata_i));
            end
        end
        if (wr_en && sel_inh) begin
            inhibit_d = N_COUNTERS'(csr_apply(csr_op_i, 32'(inhibit_q), csr_wdata_i));
        end
        // W1C for WRITE/SET and plain CLEAR coincide: old & ~wdata.
        if (wr_en && sel_ovf) begin
            ovf_d = ovf_q & ~csr_wdata_i[N_COUNTERS-1:0];
        end
        ovf_d = ovf_d | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_COUNTERS); i++) begin
                cnt_q[i]   <= '0;
                evsel_q[i] <= '0;
            end
            inhibit_q <= '0;
            ovf_q     <= '0;
            inc_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            evsel_q   <= evsel_d;
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            inc_q     <= inc_d;
        end
    end

`ifdef ZERORISCY_HPM_OVF_IRQ_EN
    logic [N_COUNTERS-1:0] irq_en_d;
    logic                  ovf_irq_q, ovf_irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && sel_irqen) begin
            irq_en_d = N_COUNTERS'(csr_apply(csr_op_i, 32'(irq_en_q), csr_wdata_i));
        end
        ovf_irq_d = |(ovf_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q  <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_d;
            ovf_irq_q <= ovf_irq_d;
        end
    end

    assign ovf_irq_o = ovf_irq_q;
`else
    assign irq_en_q  = '0;
    assign ovf_irq_o = 1'b0;
`endif

endmodule
